// File: rtl/ksa_rr_arbiter_pkg.sv
// Shared definitions for the round-robin adder arbiter.
//   id_width  : requester-ID width for a given requester count
//   rsp_width : response record width ({c_out, sum})
//   rr_first  : first set request bit scanning upward from a pointer, with wrap
package ksa_rr_arbiter_pkg;

  localparam int MAX_REQ = 32;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int rsp_width(input int width);
    return width + 1;
  endfunction

  // Returns -1 when no bit in req[n-1:0] is set. Scanning from the highest
  // offset down lets the lowest offset from ptr win the final assignment.
  function automatic int rr_first(input logic [MAX_REQ-1:0] req, input int n, input int ptr);
    int idx;
    rr_first = -1;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx]) rr_first = idx;
      end
    end
  endfunction

endpackage

// File: rtl/koggie_stone_adder.sv
// Kogge-Stone parallel-prefix adder, purely combinational.
//   a, b  : operands
//   c_in  : carry in
//   sum   : (a + b + c_in) mod 2^WIDTH
//   c_out : carry out of bit WIDTH-1
module koggie_stone_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g_n;
  logic [WIDTH-1:0] p_n;
  logic [WIDTH-1:0] carry;

  assign p0 = a ^ b;

  // Carry-in is folded into bit 0's generate so the prefix tree needs no extra column.
  always_comb begin
    g      = a & b;
    g[0]   = g[0] | (p0[0] & c_in);
    p      = p0;
    g_n    = '0;
    p_n    = '0;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      g_n = g;
      p_n = p;
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= d) begin
          g_n[i] = g[i] | (p[i] & g[i-d]);
          p_n[i] = p[i] & p[i-d];
        end
      end
      g = g_n;
      p = p_n;
    end
  end

  assign carry = {g[WIDTH-2:0], c_in};
  assign sum   = p0 ^ carry;
  assign c_out = g[WIDTH-1];

endmodule

// File: rtl/ksa_rr_arbiter_rr_arbiter.sv
// Round-robin arbiter, reusable for any shared datapath.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   en        : qualifies the one-hot grant (index is reported regardless)
//   grant     : one-hot grant, zero when en=0 or no request
//   grant_idx : encoded index of the winning request
//   grant_any : some request is pending
module rr_arbiter
  import ksa_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  logic [MAX_REQ-1:0] req_ext;
  int                 first;

  always_comb begin
    req_ext   = MAX_REQ'(req);
    first     = rr_first(req_ext, N_REQ, int'(ptr));
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (first >= 0) begin
      grant_idx = ID_W'(first);
      grant_any = 1'b1;
      if (en) grant[first] = 1'b1;
    end
  end

endmodule

// File: rtl/ksa_rr_arbiter.sv
// Shares one Kogge-Stone adder among N_REQ requesters with round-robin grants.
// Two-stage pipeline: S1 operand register -> adder -> S2 response register.
//   clk, reset          : clock, async active-low reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b, req_c : packed per-requester operands and carry-in
//   rsp_valid/rsp_ready : response handshake with back-pressure
//   rsp_data, rsp_id    : {c_out, sum} and issuing requester index
//   busy                : either pipeline stage holds data
module ksa_rr_arbiter
  import ksa_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_c,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH:0]         rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  localparam int RSP_W = rsp_width(WIDTH);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_c;
  logic [ID_W-1:0]  s1_id;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_next;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic             s2_ready;
  logic             s1_ready;
  logic             arb_en;
  logic             accept;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  assign s2_ready = !rsp_valid || rsp_ready;
  assign s1_ready = !s1_valid || s2_ready;
  // Gating with reset keeps req_ready low for the whole time reset is held.
  assign arb_en   = s1_ready && reset;
  assign accept   = grant_any && arb_en;
  assign rr_next  = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign busy     = s1_valid || rsp_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  koggie_stone_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a     (s1_a),
    .b     (s1_b),
    .c_in  (s1_c),
    .sum   (sum),
    .c_out (c_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_c      <= 1'b0;
      s1_id     <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      if (s1_valid && s2_ready) begin
        rsp_valid <= 1'b1;
        rsp_data  <= RSP_W'({c_out, sum});
        rsp_id    <= s1_id;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
        s1_b     <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
        s1_c     <= req_c[grant_idx];
        s1_id    <= grant_idx;
        rr_ptr   <= rr_next;
      end else if (s2_ready) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ksa_rr_arbiter.sv
module tb_ksa_rr_arbiter;

  localparam int WIDTH = 64;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_c;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH:0]         rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  ksa_rr_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    @(posedge clk);
    @(posedge clk);
    #3 reset  = 1'b1;
    cyc();
  endtask

  task automatic set_ops(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_c[id] = c;
  endtask

  // ---------------- reference model for the random regression ----------------
  typedef struct {
    logic [WIDTH:0] data;
    int             id;
    bit             vis;
  } exp_t;

  exp_t q[$];
  int   m_ptr;

  task automatic model_cycle(input bit rnd);
    bit             rv, pending, s2r, s1r;
    int             g, idx;
    logic [N_REQ-1:0] exp_rr;
    logic [WIDTH-1:0] a, b;
    exp_t           e;
    if (rnd) begin
      req_valid = N_REQ'($urandom);
      for (int i = 0; i < N_REQ; i++)
        set_ops(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end else begin
      req_valid = '0;
      rsp_ready = 1'b1;
    end
    #1;
    rv      = (q.size() > 0) && q[0].vis;
    pending = (q.size() > 0) && !q[q.size()-1].vis;
    s2r     = !rv || rsp_ready;
    s1r     = !pending || s2r;
    g = -1;
    for (int j = 0; j < N_REQ; j++) begin
      idx = (m_ptr + j) % N_REQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    exp_rr = (g >= 0 && s1r) ? N_REQ'(1 << g) : '0;

    chk("rnd_req_ready", (WIDTH+1)'(req_ready), (WIDTH+1)'(exp_rr));
    chk("rnd_rsp_valid", (WIDTH+1)'(rsp_valid), (WIDTH+1)'(rv));
    chk("rnd_busy", (WIDTH+1)'(busy), (WIDTH+1)'(q.size() > 0));
    if (rv) begin
      chk("rnd_rsp_data", rsp_data, q[0].data);
      chk("rnd_rsp_id", (WIDTH+1)'(rsp_id), (WIDTH+1)'(q[0].id));
    end

    if (rv && rsp_ready) void'(q.pop_front());
    if (pending && s2r) q[q.size()-1].vis = 1'b1;
    if (exp_rr != '0) begin
      a = req_a[g*WIDTH +: WIDTH];
      b = req_b[g*WIDTH +: WIDTH];
      e.data = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(req_c[g]);
      e.id   = g;
      e.vis  = 1'b0;
      q.push_back(e);
      m_ptr = (g + 1) % N_REQ;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int               id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH:0]   exp;
  } vec_t;

  vec_t vecs[6];
  int   acc[N_REQ];
  logic [WIDTH:0] held;

  initial begin
    vecs[0] = '{2, 64'd5, 64'd7, 1'b1, 65'd13};
    vecs[1] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 65'h1_0000_0000_0000_0000};
    vecs[2] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{0, 64'd0, 64'd0, 1'b0, 65'd0};
    vecs[4] = '{3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 65'h1_0000_0000_0000_0000};
    vecs[5] = '{1, 64'd123456789, 64'd987654321, 1'b0, 65'd1111111110};

    // reset state, with requests already asserted
    reset = 1'b0; req_valid = '1; rsp_ready = 1'b1; req_a = '0; req_b = '0; req_c = '0;
    #13;
    chk("reset_req_ready", (WIDTH+1)'(req_ready), '0);
    chk("reset_rsp_valid", (WIDTH+1)'(rsp_valid), '0);
    chk("reset_rsp_data", rsp_data, '0);
    chk("reset_rsp_id", (WIDTH+1)'(rsp_id), '0);
    chk("reset_busy", (WIDTH+1)'(busy), '0);
    do_reset();

    // single-request table
    for (int v = 0; v < 6; v++) begin
      set_ops(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].c);
      req_valid = N_REQ'(1 << vecs[v].id);
      rsp_ready = 1'b1;
      #1;
      chk("vec_req_ready", (WIDTH+1)'(req_ready), (WIDTH+1)'(1 << vecs[v].id));
      cyc();
      req_valid = '0;
      #1;
      chk("vec_latency_s1", (WIDTH+1)'(rsp_valid), '0);
      chk("vec_busy", (WIDTH+1)'(busy), 1);
      cyc();
      chk("vec_rsp_valid", (WIDTH+1)'(rsp_valid), 1);
      chk("vec_rsp_data", rsp_data, vecs[v].exp);
      chk("vec_rsp_id", (WIDTH+1)'(rsp_id), (WIDTH+1)'(vecs[v].id));
      cyc();
      chk("vec_rsp_done", (WIDTH+1)'(rsp_valid), '0);
      chk("vec_idle", (WIDTH+1)'(busy), '0);
    end

    // fairness: all requesters valid, no back-pressure
    do_reset();
    for (int i = 0; i < N_REQ; i++) acc[i] = 0;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      #1;
      chk("fair_grant", (WIDTH+1)'(req_ready), (WIDTH+1)'(1 << (k % N_REQ)));
      if (k > 1) chk("fair_rsp_id", (WIDTH+1)'(rsp_id), (WIDTH+1)'((k - 2) % N_REQ));
      for (int i = 0; i < N_REQ; i++) if (req_valid[i] && req_ready[i]) acc[i]++;
      cyc();
    end
    for (int i = 0; i < N_REQ; i++) chk("fair_count", (WIDTH+1)'(acc[i]), 65'd100);
    req_valid = '0;
    cyc(); cyc(); cyc();

    // back-pressure: 5 cycles of rsp_ready=0
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_ops(i, 64'(i * 100 + 7), 64'(i), 1'b0);
    req_valid = '1;
    rsp_ready = 1'b0;
    acc[0] = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (req_ready != '0) acc[0]++;
      if (k == 2) held = rsp_data;
      if (k >= 2) begin
        chk("bp_s1_full_ready", (WIDTH+1)'(req_ready), '0);
        chk("bp_rsp_data_stable", rsp_data, 65'd7);
      end
      cyc();
    end
    chk("bp_accepts", (WIDTH+1)'(acc[0]), 65'd2);
    chk("bp_held", held, 65'd7);
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    chk("bp_drain0_id", (WIDTH+1)'(rsp_id), 0);
    chk("bp_drain0_data", rsp_data, 65'd7);
    cyc();
    chk("bp_drain1_valid", (WIDTH+1)'(rsp_valid), 1);
    chk("bp_drain1_id", (WIDTH+1)'(rsp_id), 1);
    chk("bp_drain1_data", rsp_data, 65'd108);
    cyc();
    chk("bp_drain_done", (WIDTH+1)'(busy), 0);

    // reset with both stages full
    do_reset();
    req_valid = '1;
    rsp_ready = 1'b0;
    cyc(); cyc();
    chk("mid_busy_before", (WIDTH+1)'(busy), 1);
    chk("mid_rsp_valid_before", (WIDTH+1)'(rsp_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rsp_valid_reset", (WIDTH+1)'(rsp_valid), 0);
    chk("mid_busy_reset", (WIDTH+1)'(busy), 0);
    @(posedge clk);
    #3 reset = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    chk("mid_first_grant", (WIDTH+1)'(req_ready), 65'd1);
    chk("mid_no_stale", (WIDTH+1)'(rsp_valid), 0);
    cyc();
    req_valid = '0;
    #1;
    chk("mid_no_stale2", (WIDTH+1)'(rsp_valid), 0);
    cyc();
    chk("mid_rsp_valid", (WIDTH+1)'(rsp_valid), 1);
    chk("mid_rsp_id", (WIDTH+1)'(rsp_id), 0);
    cyc();
    chk("mid_done", (WIDTH+1)'(rsp_valid), 0);

    // random regression against the queue model
    do_reset();
    m_ptr = 0;
    q.delete();
    for (int k = 0; k < 10000; k++) model_cycle(1'b1);
    for (int k = 0; k < 4; k++) model_cycle(1'b0);
    chk("rnd_all_returned", (WIDTH+1)'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
